lzc_sync: RTL and testbench



---
 rtl/lzc_sync.sv | 87 ++++++++
 tb/tb_lzc_sync.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lzc_sync.sv
// Leading/trailing zero counter built as a log2 priority-select tree, with an
// optional registered output stage for timing closure.
module lzc_sync #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned MODE      = 0,
  parameter int unsigned OUT_REG   = 0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  localparam int NUM_LEAVES = 2 ** CNT_WIDTH;
  localparam int NUM_LEVELS = CNT_WIDTH + 1;

  if (WIDTH == 0) begin : g_bad_width
    $fatal(1, "lzc_sync: WIDTH must be at least 1");
  end
  if (CNT_WIDTH != ((WIDTH > 1) ? $clog2(WIDTH) : 1)) begin : g_bad_cnt_width
    $fatal(1, "lzc_sync: CNT_WIDTH is derived from WIDTH and must not be overridden");
  end

  logic [NUM_LEAVES-1:0] leaf;
  logic                  lvl_sel [NUM_LEVELS][NUM_LEAVES];
  logic [CNT_WIDTH-1:0]  lvl_idx [NUM_LEVELS][NUM_LEAVES];
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic                  empty_d;

  // Leading mode scans from the MSB, so the leaves are the bit-reversed input.
  // Padding leaves beyond WIDTH stay constant 0 and drop out in synthesis.
  always_comb begin : leaf_map
    leaf = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      leaf[i] = (MODE != 0) ? in_i[WIDTH-1-i] : in_i[i];
    end
  end

  // Level CNT_WIDTH holds the leaves; each node prefers its lower-index child.
  always_comb begin : reduce_tree
    for (int l = 0; l < NUM_LEVELS; l++) begin
      for (int k = 0; k < NUM_LEAVES; k++) begin
        lvl_sel[l][k] = 1'b0;
        lvl_idx[l][k] = '0;
      end
    end
    for (int k = 0; k < NUM_LEAVES; k++) begin
      lvl_sel[CNT_WIDTH][k] = leaf[k];
      lvl_idx[CNT_WIDTH][k] = CNT_WIDTH'(k);
    end
    for (int l = CNT_WIDTH - 1; l >= 0; l--) begin
      for (int k = 0; k < NUM_LEAVES / 2; k++) begin
        lvl_sel[l][k] = lvl_sel[l+1][2*k] | lvl_sel[l+1][2*k+1];
        lvl_idx[l][k] = lvl_sel[l+1][2*k] ? lvl_idx[l+1][2*k] : lvl_idx[l+1][2*k+1];
      end
    end
  end

  assign empty_d = ~lvl_sel[0][0];
  assign cnt_d   = empty_d ? '0 : lvl_idx[0][0];

  if (OUT_REG != 0) begin : g_out_reg
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 empty_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        cnt_q   <= '0;
        empty_q <= 1'b1;
      end else begin
        cnt_q   <= cnt_d;
        empty_q <= empty_d;
      end
    end

    assign cnt_o   = cnt_q;
    assign empty_o = empty_q;
  end else begin : g_out_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign cnt_o          = cnt_d;
    assign empty_o        = empty_d;
  end

endmodule

// File: tb/tb_lzc_sync.sv
// Bench for lzc_sync: a bank of combinational instances over several widths and
// both modes sharing one input bus, plus one registered WIDTH=8 trailing instance.
module tb_lzc_sync;

  localparam int N_COMB = 14;
  localparam int W_TAB [N_COMB] = '{1, 1, 2, 2, 3, 3, 5, 5, 7, 7, 8, 8, 16, 16};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [15:0] vec   = '0;
  logic [7:0]  in_r  = '0;
  logic [2:0]  cnt_r;
  logic        empty_r;
  logic [4:0]  obs [N_COMB];

  // scoreboard queues: {id[3:0], empty, cnt[3:0]} and {empty, cnt[2:0]}
  logic [8:0] exp_q[$];
  logic [3:0] reg_q[$];
  int checks = 0;
  int errors = 0;
  logic [8:0] mon_e;
  logic [3:0] mon_r;

  // even ids are trailing mode, odd ids leading mode
  for (genvar g = 0; g < N_COMB; g++) begin : g_dut
    localparam int W  = W_TAB[g];
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    logic [CW-1:0] cnt;
    logic          empty;
    lzc_sync #(.WIDTH(W), .MODE(g % 2), .OUT_REG(0)) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .in_i    (vec[W-1:0]),
      .cnt_o   (cnt),
      .empty_o (empty)
    );
    assign obs[g] = {empty, 4'(cnt)};
  end

  lzc_sync #(.WIDTH(8), .MODE(0), .OUT_REG(1)) u_reg (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .in_i    (in_r),
    .cnt_o   (cnt_r),
    .empty_o (empty_r)
  );

  function automatic logic [4:0] ref_lzc(input logic [15:0] v, input int w, input int mode);
    int  cnt   = 0;
    bit  found = 1'b0;
    for (int i = 0; i < w; i++) begin
      int b = (mode != 0) ? (w - 1 - i) : i;
      if (!found && v[b]) begin
        found = 1'b1;
        cnt   = i;
      end
    end
    return found ? {1'b0, 4'(cnt)} : 5'b10000;
  endfunction

  // driver tasks
  task automatic drive(input logic [15:0] v);
    @(negedge clk);
    vec = v;
  endtask

  task automatic push_dir(input int id, input logic e, input int c);
    exp_q.push_back({4'(id), e, 4'(c)});
  endtask

  task automatic push_all();
    for (int id = 0; id < N_COMB; id++) begin
      exp_q.push_back({4'(id), ref_lzc(vec, W_TAB[id], id % 2)});
    end
  endtask

  // Input is scrambled right after the capture edge so a missing register shows up.
  task automatic reg_step(input logic rst, input logic [7:0] d, input logic [3:0] exp_v);
    @(negedge clk);
    rst_n = rst;
    in_r  = d;
    reg_q.push_back(exp_v);
    @(posedge clk);
    #1;
    in_r = ~d;
  endtask

  // monitor: outputs are sampled 2 time units after the rising edge
  always @(posedge clk) begin
    #2;
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (obs[mon_e[8:5]] !== mon_e[4:0]) begin
        errors++;
        $display("FAIL comb id=%0d in=%h got empty=%0b cnt=%0d want empty=%0b cnt=%0d",
                 mon_e[8:5], vec, obs[mon_e[8:5]][4], obs[mon_e[8:5]][3:0], mon_e[4], mon_e[3:0]);
      end
    end
    if (reg_q.size() > 0) begin
      mon_r = reg_q.pop_front();
      checks++;
      if ({empty_r, cnt_r} !== mon_r) begin
        errors++;
        $display("FAIL reg got empty=%0b cnt=%0d want empty=%0b cnt=%0d",
                 empty_r, cnt_r, mon_r[3], mon_r[2:0]);
      end
    end
  end

  initial begin
    // directed vectors, ids: 0/1 W1, 6/7 W5, 10/11 W8, 12/13 W16
    drive(16'h0028);
    push_dir(10, 1'b0, 3); push_dir(11, 1'b0, 2);
    push_dir(6, 1'b0, 3);  push_dir(7, 1'b0, 1);
    drive(16'h0080);
    push_dir(10, 1'b0, 7); push_dir(11, 1'b0, 0);
    drive(16'h0001);
    push_dir(10, 1'b0, 0); push_dir(11, 1'b0, 7);
    push_dir(6, 1'b0, 0);  push_dir(7, 1'b0, 4);
    push_dir(0, 1'b0, 0);  push_dir(1, 1'b0, 0);
    drive(16'h00FF);
    push_dir(10, 1'b0, 0); push_dir(11, 1'b0, 0);
    drive(16'h0000);
    push_dir(10, 1'b1, 0); push_dir(11, 1'b1, 0);
    push_dir(6, 1'b1, 0);  push_dir(7, 1'b1, 0);
    push_dir(0, 1'b1, 0);  push_dir(1, 1'b1, 0);
    push_dir(12, 1'b1, 0); push_dir(13, 1'b1, 0);
    drive(16'h0010);
    push_dir(6, 1'b0, 4);  push_dir(7, 1'b0, 0);
    push_dir(10, 1'b0, 4); push_dir(11, 1'b0, 3);
    drive(16'h0006);
    push_dir(6, 1'b0, 1);  push_dir(7, 1'b0, 2);
    drive(16'h8000);
    push_dir(12, 1'b0, 15); push_dir(13, 1'b0, 0);
    push_dir(10, 1'b1, 0);  push_dir(11, 1'b1, 0);

    // exhaustive for widths up to 8, then random for width 16
    for (int v = 0; v < 256; v++) begin
      drive(16'(v));
      push_all();
    end
    for (int n = 0; n < 10000; n++) begin
      drive(16'($urandom_range(0, 65535)));
      push_all();
    end

    // registered instance
    reg_step(1'b0, 8'h5A, 4'b1000);
    reg_step(1'b0, 8'h5A, 4'b1000);
    reg_step(1'b1, 8'h10, 4'b0100);
    reg_step(1'b1, 8'h00, 4'b1000);
    reg_step(1'b1, 8'h28, 4'b0011);
    reg_step(1'b0, 8'h04, 4'b1000);
    reg_step(1'b1, 8'h04, 4'b0010);
    reg_step(1'b1, 8'h80, 4'b0111);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || reg_q.size() != 0) begin
      errors++;
      $display("FAIL drain got comb=%0d reg=%0d pending want 0", exp_q.size(), reg_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
